store_drain_buffer: RTL and testbench

Posted-write buffer between the CPU store path and a slow memory port (frame buffer / I/O space). Stores already carrying a per-byte write mask are captured in a small FIFO so the pipeline does not wait on the memory handshake. Entries drain in order over a level req / pulse ack interface. A load-address check flags read-after-write hazards against pending entries.

---
 rtl/store_drain_buffer_pkg.sv | 27 ++
 rtl/store_drain_buffer_fifo.sv | 67 ++++++
 rtl/store_drain_buffer.sv | 122 ++++++++++++
 tb/tb_store_drain_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_drain_buffer_pkg.sv
// Shared types and constants for the posted-write store drain buffer.
package store_drain_buffer_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int MASK_W    = 4;
  localparam int WA_HI     = 31;
  localparam int WA_LO     = 2;
  localparam int WA_W      = WA_HI - WA_LO + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [WA_W-1:0]   addr;
    logic [31:0]       data;
    logic [MASK_W-1:0] mask;
  } entry_t;

  function automatic logic [WA_W-1:0] word_addr(
    input logic [31:0] a
  );
    return a[WA_HI:WA_LO];
  endfunction

endpackage

// File: rtl/store_drain_buffer_fifo.sv
// In-order store FIFO with head, next-head and per-entry address taps
// so the top can run back-to-back drains and load hazard compares.
module store_fifo
  import store_drain_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     din,
  input  logic                       pop,
  output entry_t                     head,
  output entry_t                     head_next,
  output logic [AW:0]                count,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           vld,
  output logic [DEPTH-1:0][WA_W-1:0] taps
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rnext;

  assign rnext     = rptr + 1'b1;
  assign head      = mem[rptr];
  assign head_next = mem[rnext];
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    assign taps[i] = mem[i].addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= din;
        vld[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rnext;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Posted-write buffer: captures masked stores, drains them in order over
// a level req / pulse ack port and flags loads that hit a pending store.
module store_drain_buffer
  import store_drain_buffer_pkg::*;
#(
  parameter int         DEPTH     = DEPTH_DEF,
  parameter logic [3:0] PARTITION = 4'h8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [MASK_W-1:0] st_mask,
  output logic              st_stall,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  output logic              ld_hazard,
  output logic              mem_req,
  output logic [WA_W-1:0]   mem_addr,
  output logic [31:0]       mem_data,
  output logic [MASK_W-1:0] mem_mask,
  input  logic              mem_ack,
  output logic              drained
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t                     state;
  entry_t                     out_q;
  entry_t                     st_ent;
  entry_t                     head;
  entry_t                     head_next;
  entry_t                     nxt;
  logic [AW:0]                count;
  logic                       full;
  logic                       empty;
  logic [DEPTH-1:0]           vld;
  logic [DEPTH-1:0][WA_W-1:0] taps;
  logic                       st_ok;
  logic                       push;
  logic                       pop;
  logic                       hit;
  logic                       unused_lsb;

  assign unused_lsb = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ok    = st_valid && (st_addr[31:28] == PARTITION)
                    && (st_mask != '0);
  assign push     = st_ok && !full;
  assign st_stall = st_ok && full;
  assign pop      = (state == ISSUE) && mem_ack;

  assign st_ent = '{addr: word_addr(st_addr),
                    data: st_data,
                    mask: st_mask};

  // with a single entry left the next head is the store arriving now
  assign nxt = (push && count == CNT_ONE) ? st_ent : head_next;

  store_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (st_ent),
    .pop      (pop),
    .head     (head),
    .head_next(head_next),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .vld      (vld),
    .taps     (taps)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state <= ISSUE;
            out_q <= head;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            if (push || count != CNT_ONE) begin
              out_q <= nxt;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req  = (state == ISSUE);
  assign mem_addr = out_q.addr;
  assign mem_data = out_q.data;
  assign mem_mask = out_q.mask;
  assign drained  = empty && (state == IDLE);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && taps[i] == word_addr(ld_addr)) begin
        hit = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_valid && (ld_addr[31:28] == PARTITION) && hit;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer with a drain-side scoreboard.
module tb_store_drain_buffer;
  import store_drain_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        st_stall;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic        drained;

  int     checks   = 0;
  int     failures = 0;
  entry_t sb[$];
  entry_t mon_e;
  int     n;

  always #5 clk = ~clk;

  store_drain_buffer #(
    .DEPTH    (4),
    .PARTITION(4'h8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_mask  (st_mask),
    .st_stall (st_stall),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_hazard(ld_hazard),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_mask (mem_mask),
    .mem_ack  (mem_ack),
    .drained  (drained)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input bit exp);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
    if (exp) sb.push_back(entry_t'{addr: a[31:2], data: d, mask: m});
  endtask

  // drain monitor: every accepted write must match the next expected store
  always @(negedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL drain_unexpected actual=%h required=none", mem_addr);
      end else begin
        mon_e = sb.pop_front();
        if ({mem_addr, mem_data, mem_mask} !== mon_e) begin
          failures++;
          $display("FAIL drain actual=%h/%h/%h required=%h/%h/%h",
                   mem_addr, mem_data, mem_mask,
                   mon_e.addr, mon_e.data, mon_e.mask);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_mask = 0;
    ld_valid = 0; ld_addr = 0; mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_drained", drained, 1);
    chk("rst_hazard", ld_hazard, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_stall", st_stall, 0);
    rst = 1'b0;
    tick();

    // single store, one-cycle issue latency
    put(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 1);
    chk("t1_stall", st_stall, 0);
    tick();
    st_valid = 0;
    chk("t1_req_early", mem_req, 0);
    tick();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h2000_0004);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("t1_req_done", mem_req, 0);
    chk("t1_drained", drained, 1);

    // ignored stores
    put(32'h1000_0000, 32'h1234_5678, 4'b1111, 0);
    chk("t2_stall_part", st_stall, 0);
    tick();
    put(32'h8000_0000, 32'h1234_5678, 4'b0000, 0);
    chk("t2_stall_mask", st_stall, 0);
    tick();
    st_valid = 0;
    tick();
    chk("t2_drained", drained, 1);
    chk("t2_req", mem_req, 0);

    // fill to full, fifth store stalls until after first ack
    for (int k = 0; k < 4; k++) begin
      put(32'h8000_0100 + 32'(4 * k), 32'h1111_0000 + 32'(k),
          4'(k + 1), 1);
      chk("t3_stall0", st_stall, 0);
      tick();
    end
    put(32'h8000_0110, 32'h1111_0004, 4'b1000, 1);
    chk("t3_stall_full", st_stall, 1);
    chk("t3_head", mem_addr, 32'h2000_0040);
    tick();
    chk("t3_stall_hold", st_stall, 1);
    mem_ack = 1;
    chk("t3_stall_ack", st_stall, 1);
    tick();
    mem_ack = 0;
    chk("t3_stall_free", st_stall, 0);
    chk("t3_head2", mem_addr, 32'h2000_0041);
    tick();
    st_valid = 0;
    mem_ack = 1;
    n = 0;
    while (mem_req && n < 20) begin
      tick();
      n++;
    end
    mem_ack = 0;
    chk("t3_drain_cycles", n, 4);
    chk("t3_drained", drained, 1);

    // store and ack every cycle across pointer wrap
    put(32'h8000_0200, 32'hA000_0000, 4'hF, 1);
    tick();
    st_valid = 0;
    tick();
    chk("t4_req0", mem_req, 1);
    for (int k = 1; k <= 12; k++) begin
      put(32'h8000_0200 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF, 1);
      mem_ack = 1;
      tick();
      chk("t4_req", mem_req, 1);
      chk("t4_count", 32'(dut.u_fifo.count), 1);
    end
    st_valid = 0;
    tick();
    mem_ack = 0;
    chk("t4_req_end", mem_req, 0);
    chk("t4_drained", drained, 1);

    // load hazard
    put(32'h8000_0020, 32'h55AA_55AA, 4'b0011, 1);
    tick();
    st_valid = 0;
    ld_valid = 1;
    ld_addr  = 32'h8000_0022;
    #1 chk("t5_hit", ld_hazard, 1);
    ld_addr = 32'h8000_0024;
    #1 chk("t5_miss", ld_hazard, 0);
    tick();
    chk("t5_req", mem_req, 1);
    ld_addr = 32'h8000_0020;
    mem_ack = 1;
    #1 chk("t5_hit_acking", ld_hazard, 1);
    tick();
    mem_ack = 0;
    chk("t5_after_ack", ld_hazard, 0);
    chk("t5_drained", drained, 1);
    put(32'h8000_0030, 32'h0000_0077, 4'b0001, 1);
    ld_addr = 32'h8000_0030;
    #1 chk("t5_enq_same", ld_hazard, 0);
    tick();
    st_valid = 0;
    #1 chk("t5_enq_next", ld_hazard, 1);
    ld_valid = 0;
    #1 chk("t5_ld_idle", ld_hazard, 0);
    tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("t5_drained2", drained, 1);

    // reset mid-transfer
    put(32'h8000_0300, 32'h0000_0001, 4'hF, 1);
    tick();
    put(32'h8000_0304, 32'h0000_0002, 4'hF, 1);
    tick();
    put(32'h8000_0308, 32'h0000_0003, 4'hF, 1);
    tick();
    st_valid = 0;
    chk("t6_req_pre", mem_req, 1);
    rst = 1;
    #1;
    sb.delete();
    chk("t6_req_rst", mem_req, 0);
    chk("t6_drained_rst", drained, 1);
    chk("t6_count_rst", 32'(dut.u_fifo.count), 0);
    #2 rst = 0;
    tick();
    put(32'h8000_0400, 32'hCAFE_F00D, 4'b1001, 1);
    tick();
    st_valid = 0;
    chk("t6_req_early", mem_req, 0);
    tick();
    chk("t6_req", mem_req, 1);
    chk("t6_addr", mem_addr, 32'h2000_0100);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("t6_drained", drained, 1);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
